// File: rtl/tinyml_dma_pkg.sv
// Shared definitions for the tinyml DMA stream endpoint: control states and
// frame-size derived constants.
package tinyml_dma_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } dma_state_t;

  function automatic int calc_nwords(input int fw, input int fh);
    return fw * fh;
  endfunction

  // Address/counter width: enough bits for word indices 0..NWORDS-1.
  function automatic int calc_aw(input int fw, input int fh);
    return (fw * fh > 1) ? $clog2(fw * fh) : 1;
  endfunction

endpackage

// File: rtl/tinyml_dma_skid_buf.sv
// Two-entry valid/ready buffer between the source memory read port and the
// MM2S stream; the head word stays stable until it is popped.
module tinyml_dma_skid_buf #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   level
);

  logic [W-1:0] slot [2];
  logic         rd_ptr;
  logic         wr_ptr;
  logic         push;
  logic         pop;

  assign in_ready  = (level != 2'd2);
  assign out_valid = (level != 2'd0);
  assign out_data  = slot[rd_ptr];
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot[0] <= '0;
      slot[1] <= '0;
      rd_ptr  <= 1'b0;
      wr_ptr  <= 1'b0;
      level   <= 2'd0;
    end else begin
      if (push) begin
        slot[wr_ptr] <= in_data;
        wr_ptr       <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      level <= level + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/tinyml_dma_stream_endpoint.sv
// Frame-level DMA endpoint: streams NWORDS source words to an accelerator
// (MM2S) and writes the accelerator's NWORDS results back to sink memory (S2MM).
module tinyml_dma_stream_endpoint
  import tinyml_dma_pkg::*;
#(
  parameter int DATA_WIDTH          = 32,
  parameter int FRAME_WIDTH         = 640,
  parameter int FRAME_HEIGHT        = 480,
  parameter int DMA_TRANSFER_LENGTH = 1920,
  localparam int AW = calc_aw(FRAME_WIDTH, FRAME_HEIGHT),
  localparam int KW = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_rd_en,
  output logic [AW-1:0]         mem_rd_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  dma_rvalid,
  input  logic                  dma_rready,
  output logic [KW-1:0]         dma_rkeep,
  output logic [DATA_WIDTH-1:0] dma_rdata,
  input  logic                  dma_wvalid,
  output logic                  dma_wready,
  input  logic                  dma_wlast,
  input  logic [DATA_WIDTH-1:0] dma_wdata,
  output logic                  mem_wr_en,
  output logic [AW-1:0]         mem_wr_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  output logic                  wlast_err
);

  localparam int NWORDS = calc_nwords(FRAME_WIDTH, FRAME_HEIGHT);
  localparam int BW     = (DMA_TRANSFER_LENGTH > 1) ? $clog2(DMA_TRANSFER_LENGTH) : 1;
  localparam logic [AW-1:0] LAST_WORD  = AW'(NWORDS - 1);
  localparam logic [BW-1:0] LAST_BURST = BW'(DMA_TRANSFER_LENGTH - 1);

  dma_state_t state, state_nx;

  logic                  start_acc;
  logic                  rd_infl;
  logic                  rd_done;
  logic [AW-1:0]         tx_cnt;
  logic [AW-1:0]         rx_cnt;
  logic                  rx_done;
  logic [BW-1:0]         burst_cnt;
  logic                  skid_in_ready;
  logic                  skid_valid;
  logic [DATA_WIDTH-1:0] skid_data;
  logic [1:0]            skid_level;
  logic                  rd_pop;
  logic [2:0]            occupancy;
  logic                  tx_last;
  logic                  rx_acc;
  logic                  rx_complete;

  tinyml_dma_skid_buf #(.W(DATA_WIDTH)) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (rd_infl),
    .in_ready (skid_in_ready),
    .in_data  (mem_rd_data),
    .out_valid(skid_valid),
    .out_ready(dma_rready),
    .out_data (skid_data),
    .level    (skid_level)
  );

  assign rd_pop     = skid_valid && dma_rready;
  assign dma_rvalid = skid_valid;
  assign dma_rdata  = skid_valid ? skid_data : '0;
  assign dma_rkeep  = {KW{skid_valid}};

  // A read is issued only if the returning word is guaranteed a slot, counting
  // the word still in flight and any pop happening this cycle.
  assign occupancy = {1'b0, skid_level} + {2'b00, rd_infl};
  assign mem_rd_en = (state == ST_RUN) && !rd_done && skid_in_ready
                     && (occupancy <= (3'd1 + {2'b00, rd_pop}));

  assign busy        = (state != ST_IDLE);
  assign dma_wready  = busy;
  assign tx_last     = rd_pop && (tx_cnt == LAST_WORD);
  assign rx_acc      = dma_wvalid && dma_wready && !rx_done;
  assign rx_complete = rx_done || (rx_acc && (rx_cnt == LAST_WORD));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    done      = 1'b0;
    start_acc = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          start_acc = 1'b1;
          state_nx  = ST_RUN;
        end
      end
      ST_RUN: begin
        if (tx_last) begin
          if (rx_complete) begin
            state_nx = ST_IDLE;
            done     = 1'b1;
          end else begin
            state_nx = ST_FLUSH;
          end
        end
      end
      ST_FLUSH: begin
        if (rx_complete) begin
          state_nx = ST_IDLE;
          done     = 1'b1;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // MM2S read side
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_rd_addr <= '0;
      rd_done     <= 1'b0;
      rd_infl     <= 1'b0;
      tx_cnt      <= '0;
    end else begin
      rd_infl <= mem_rd_en;
      if (start_acc) begin
        mem_rd_addr <= '0;
        rd_done     <= 1'b0;
        tx_cnt      <= '0;
      end else begin
        if (mem_rd_en) begin
          if (mem_rd_addr == LAST_WORD) rd_done <= 1'b1;
          else                          mem_rd_addr <= mem_rd_addr + 1'b1;
        end
        if (rd_pop && (tx_cnt != LAST_WORD)) begin
          tx_cnt <= tx_cnt + 1'b1;
        end
      end
    end
  end

  // S2MM write side
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_cnt      <= '0;
      rx_done     <= 1'b0;
      burst_cnt   <= '0;
      wlast_err   <= 1'b0;
      mem_wr_en   <= 1'b0;
      mem_wr_addr <= '0;
      mem_wr_data <= '0;
    end else begin
      mem_wr_en <= rx_acc;
      if (start_acc) begin
        rx_cnt    <= '0;
        rx_done   <= 1'b0;
        burst_cnt <= '0;
        wlast_err <= 1'b0;
      end else if (rx_acc) begin
        mem_wr_addr <= rx_cnt;
        mem_wr_data <= dma_wdata;
        if (rx_cnt == LAST_WORD) rx_done <= 1'b1;
        else                     rx_cnt  <= rx_cnt + 1'b1;
        burst_cnt <= (burst_cnt == LAST_BURST) ? '0 : burst_cnt + 1'b1;
        if (dma_wlast != (burst_cnt == LAST_BURST)) wlast_err <= 1'b1;
      end
    end
  end

endmodule

// File: doc/tinyml_dma_stream_endpoint.md
TINYML_DMA_STREAM_ENDPOINT -- requirements
Module: tinyml_dma_stream_endpoint

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- DATA_WIDTH, 32, stream and memory word width.
- FRAME_WIDTH, 640, pixels per line.
- FRAME_HEIGHT, 480, lines per frame.
- DMA_TRANSFER_LENGTH, 1920, words per write burst.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-003 Ports SHALL be, one per line (name, direction, width, meaning):
- clk, in, 1, sole clock.
- rst_n, in, 1, async active-low reset.
- start, in, 1, one-cycle frame start pulse.
- busy, out, 1, frame in progress.
- done, out, 1, one-cycle frame-complete pulse.
- mem_rd_en, out, 1, source memory read strobe.
- mem_rd_addr, out, AW, word address; AW=$clog2(FRAME_WIDTH*FRAME_HEIGHT).
- mem_rd_data, in, DATA_WIDTH, read data, valid exactly 1 cycle after mem_rd_en.
- dma_rvalid, out, 1, MM2S stream valid to accelerator.
- dma_rready, in, 1, accelerator accept.
- dma_rkeep, out, DATA_WIDTH/8, byte keep.
- dma_rdata, out, DATA_WIDTH, MM2S data.
- dma_wvalid, in, 1, S2MM valid from accelerator.
- dma_wready, out, 1, S2MM accept.
- dma_wlast, in, 1, burst end marker.
- dma_wdata, in, DATA_WIDTH, S2MM data.
- mem_wr_en, out, 1, sink memory write strobe.
- mem_wr_addr, out, AW, sink word address.
- mem_wr_data, out, DATA_WIDTH, sink write data.
- wlast_err, out, 1, sticky wlast position error.

Function
REQ-004 NWORDS SHALL equal FRAME_WIDTH*FRAME_HEIGHT; start SHALL be honoured only when busy=0 and ignored otherwise.
REQ-005 Control FSM states SHALL be IDLE, RUN, FLUSH: IDLE->RUN on start; RUN->FLUSH when the last MM2S word is accepted; FLUSH->IDLE when NWORDS S2MM words have been received, pulsing done for that cycle; a transition to IDLE from RUN SHALL also occur if both counts complete in the same cycle.
REQ-006 busy SHALL be 1 in RUN and FLUSH.
REQ-007 MM2S path: mem_rd_addr SHALL increment 0..NWORDS-1; a 2-entry skid buffer SHALL absorb the 1-cycle read latency; mem_rd_en SHALL assert only when the buffer has room for the returning word counting in-flight reads.
REQ-008 dma_rvalid SHALL assert whenever the buffer is non-empty and SHALL hold dma_rdata stable until dma_rvalid&&dma_rready.
REQ-009 dma_rkeep SHALL be all-ones while dma_rvalid=1 and zero otherwise.
REQ-010 Exactly NWORDS MM2S transfers per frame: no mem read past NWORDS-1, no extra rvalid.
REQ-011 S2MM path: dma_wready SHALL be 1 in RUN and FLUSH and 0 in IDLE; each dma_wvalid&&dma_wready SHALL produce, next cycle, mem_wr_en=1 with mem_wr_addr=rx count and mem_wr_data=dma_wdata.
REQ-012 A burst counter SHALL wrap 0..DMA_TRANSFER_LENGTH-1.
REQ-013 wlast_err SHALL set when a received word has dma_wlast mismatching (burst count==DMA_TRANSFER_LENGTH-1), and SHALL clear only on reset or accepted start.
REQ-014 dma_wvalid in IDLE SHALL be ignored (no write, no count).
REQ-015 Counters SHALL use AW bits, with no wrap within a frame; all counts SHALL reset to 0 on accepted start.

Reset
REQ-016 On rst_n=0 (async): FSM=IDLE; busy, done, mem_rd_en, mem_wr_en, dma_rvalid, dma_wready and wlast_err SHALL be 0; addresses, counters and the skid buffer SHALL be emptied/zeroed; dma_rkeep and dma_rdata SHALL be 0.
REQ-017 Reset mid-frame SHALL abandon the frame without generating done; the next start SHALL begin at address 0.

Structure
REQ-018 The FSM state encoding and the NWORDS/AW derivation SHALL live in a shared package tinyml_dma_pkg.
REQ-019 The skid buffer SHALL be one sub-module, tinyml_dma_skid_buf (2-deep, valid/ready both sides).

Verification (FRAME_WIDTH=4, FRAME_HEIGHT=4, DMA_TRANSFER_LENGTH=8, NWORDS=16)
REQ-020 Benches SHALL cover:
- start, rready=1, loopback w<=r with wlast every 8th -> 16 rdata equal mem[0..15], mem_wr 0..15, done once, wlast_err=0.
- rready toggled 1-0-0-1 randomly -> rdata stable while stalled, no word lost or duplicated, exactly 16 beats.
- wlast driven on word 6 instead of 7 -> wlast_err=1 from the next cycle, stays 1 until next start.
- start pulsed during busy -> ignored, counts unchanged, single done.
- rst_n low after 5 MM2S beats -> all outputs 0 immediately; new start reads from address 0.
- dma_wvalid=1 in IDLE -> no mem_wr_en, dma_wready=0.
